// File: rtl/fpu_mul_arbiter.sv
// Two-requester round-robin front end for a shared single-precision multiplier.
// One transaction in flight; operands and products pass through untouched.
module fpu_mul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic        req_stb_0,
    output logic        req_ack_0,
    output logic [31:0] result_0,
    output logic        result_stb_0,
    input  logic        result_ack_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic        req_stb_1,
    output logic        req_ack_1,
    output logic [31:0] result_1,
    output logic        result_stb_1,
    input  logic        result_ack_1,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_a_stb,
    output logic        mul_b_stb,
    input  logic        mul_a_ack,
    input  logic        mul_b_ack,
    input  logic [31:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_z_ack,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_Z,
        DELIVER
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   a_done;
    logic   b_done;
    logic   own_ack;

    // On a tie the requester that did not win last time gets the multiplier.
    always_comb begin
        grant = req_stb_1;
        if (req_stb_0 && req_stb_1) begin
            grant = ~last_grant;
        end
    end

    assign a_done  = !mul_a_stb || mul_a_ack;
    assign b_done  = !mul_b_stb || mul_b_ack;
    assign own_ack = owner ? result_ack_1 : result_ack_0;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            req_ack_0    <= 1'b0;
            req_ack_1    <= 1'b0;
            mul_a        <= 32'h0;
            mul_b        <= 32'h0;
            mul_a_stb    <= 1'b0;
            mul_b_stb    <= 1'b0;
            mul_z_ack    <= 1'b0;
            result_0     <= 32'h0;
            result_1     <= 32'h0;
            result_stb_0 <= 1'b0;
            result_stb_1 <= 1'b0;
        end else begin
            req_ack_0 <= 1'b0;
            req_ack_1 <= 1'b0;
            mul_z_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_stb_0 || req_stb_1) begin
                        owner      <= grant;
                        last_grant <= grant;
                        mul_a      <= grant ? req_a_1 : req_a_0;
                        mul_b      <= grant ? req_b_1 : req_b_0;
                        req_ack_0  <= ~grant;
                        req_ack_1  <= grant;
                        mul_a_stb  <= 1'b1;
                        mul_b_stb  <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (mul_a_ack) begin
                        mul_a_stb <= 1'b0;
                    end
                    if (mul_b_ack) begin
                        mul_b_stb <= 1'b0;
                    end
                    if (a_done && b_done) begin
                        state <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (mul_z_stb) begin
                        mul_z_ack <= 1'b1;
                        if (owner) begin
                            result_1     <= mul_z;
                            result_stb_1 <= 1'b1;
                        end else begin
                            result_0     <= mul_z;
                            result_stb_0 <= 1'b1;
                        end
                        state <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (own_ack) begin
                        result_stb_0 <= 1'b0;
                        result_stb_1 <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter; the bench plays both requesters
// and the multiplier, with hand-computed IEEE-754 products.
module tb_fpu_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic        req_stb_0, req_stb_1;
    logic        req_ack_0, req_ack_1;
    logic [31:0] result_0, result_1;
    logic        result_stb_0, result_stb_1;
    logic        result_ack_0, result_ack_1;
    logic [31:0] mul_a, mul_b, mul_z;
    logic        mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack;
    logic        mul_z_stb, mul_z_ack;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_mul_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_stb_0(req_stb_0), .req_ack_0(req_ack_0),
        .result_0(result_0), .result_stb_0(result_stb_0),
        .result_ack_0(result_ack_0),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_stb_1(req_stb_1), .req_ack_1(req_ack_1),
        .result_1(result_1), .result_stb_1(result_stb_1),
        .result_ack_1(result_ack_1),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a_0 = 0; req_b_0 = 0; req_stb_0 = 0; result_ack_0 = 0;
        req_a_1 = 0; req_b_1 = 0; req_stb_1 = 0; result_ack_1 = 0;
        mul_a_ack = 0; mul_b_ack = 0; mul_z = 0; mul_z_stb = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Grant edge plus both multiplier operand acks in the same cycle.
    task automatic grant(input logic k, input logic [31:0] a,
                         input logic [31:0] b);
        tick();
        chk("grant_owner", {31'h0, owner}, {31'h0, k});
        chk("grant_ack_own", {31'h0, k ? req_ack_1 : req_ack_0}, 32'h1);
        chk("grant_ack_other", {31'h0, k ? req_ack_0 : req_ack_1}, 32'h0);
        chk("grant_mul_a", mul_a, a);
        chk("grant_mul_b", mul_b, b);
        chk("grant_stbs", {30'h0, mul_a_stb, mul_b_stb}, 32'h3);
        chk("grant_busy", {31'h0, busy}, 32'h1);
        if (k) req_stb_1 = 1'b0;
        else   req_stb_0 = 1'b0;
        mul_a_ack = 1'b1;
        mul_b_ack = 1'b1;
        tick();
        mul_a_ack = 1'b0;
        mul_b_ack = 1'b0;
        chk("send_stbs_drop", {30'h0, mul_a_stb, mul_b_stb}, 32'h0);
        chk("req_ack_pulse", {30'h0, req_ack_1, req_ack_0}, 32'h0);
    endtask

    task automatic capture(input logic k, input logic [31:0] z);
        mul_z = z;
        mul_z_stb = 1'b1;
        tick();
        mul_z_stb = 1'b0;
        chk("cap_result", k ? result_1 : result_0, z);
        chk("cap_stb_own", {31'h0, k ? result_stb_1 : result_stb_0}, 32'h1);
        chk("cap_stb_other", {31'h0, k ? result_stb_0 : result_stb_1}, 32'h0);
        chk("cap_z_ack", {31'h0, mul_z_ack}, 32'h1);
        tick();
        chk("z_ack_one_cycle", {31'h0, mul_z_ack}, 32'h0);
        chk("deliver_hold", {31'h0, k ? result_stb_1 : result_stb_0}, 32'h1);
    endtask

    task automatic release_res(input logic k);
        if (k) result_ack_1 = 1'b1;
        else   result_ack_0 = 1'b1;
        tick();
        result_ack_0 = 1'b0;
        result_ack_1 = 1'b0;
        chk("rel_stbs", {30'h0, result_stb_1, result_stb_0}, 32'h0);
        chk("rel_busy", {31'h0, busy}, 32'h0);
    endtask

    logic [31:0] held;
    int          bad;

    initial begin
        // Reset state
        do_reset();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_owner", {31'h0, owner}, 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_mul_b", mul_b, 32'h0);
        chk("rst_results", result_0 | result_1, 32'h0);
        chk("rst_flags", {26'h0, req_ack_0, req_ack_1, mul_a_stb,
                          mul_b_stb, mul_z_ack, result_stb_0}, 32'h0);

        // Single op 2*3 = 6
        req_a_0 = 32'h40000000; req_b_0 = 32'h40400000; req_stb_0 = 1'b1;
        grant(1'b0, 32'h40000000, 32'h40400000);
        capture(1'b0, 32'h40C00000);
        repeat (3) begin
            tick();
            chk("single_stable", result_0, 32'h40C00000);
            chk("single_stb", {31'h0, result_stb_0}, 32'h1);
        end
        release_res(1'b0);

        // Tie after reset: req0 (1*-4) first, then alternate 0,1,0,1
        do_reset();
        req_a_0 = 32'h3F800000; req_b_0 = 32'hC0800000; req_stb_0 = 1'b1;
        req_a_1 = 32'hC0400000; req_b_1 = 32'h40000000; req_stb_1 = 1'b1;
        grant(1'b0, 32'h3F800000, 32'hC0800000);
        capture(1'b0, 32'hC0800000);
        release_res(1'b0);
        req_stb_0 = 1'b1;
        grant(1'b1, 32'hC0400000, 32'h40000000);
        capture(1'b1, 32'hC0C00000);
        release_res(1'b1);
        req_stb_1 = 1'b1;
        grant(1'b0, 32'h3F800000, 32'hC0800000);
        capture(1'b0, 32'hC0800000);
        release_res(1'b0);
        grant(1'b1, 32'hC0400000, 32'h40000000);
        capture(1'b1, 32'hC0C00000);
        release_res(1'b1);

        // Split acks: b acked three cycles after a; early z_stb ignored
        do_reset();
        req_a_0 = 32'h40A00000; req_b_0 = 32'h3F000000; req_stb_0 = 1'b1;
        tick();
        chk("split_grant", {31'h0, req_ack_0}, 32'h1);
        req_stb_0 = 1'b0;
        mul_a_ack = 1'b1;
        mul_z = 32'h40200000;
        mul_z_stb = 1'b1;
        tick();
        mul_a_ack = 1'b0;
        chk("split_a_drop", {31'h0, mul_a_stb}, 32'h0);
        chk("split_b_held", {31'h0, mul_b_stb}, 32'h1);
        tick();
        chk("split_b_held2", {31'h0, mul_b_stb}, 32'h1);
        chk("split_b_stable", mul_b, 32'h3F000000);
        tick();
        chk("split_b_held3", {31'h0, mul_b_stb}, 32'h1);
        chk("split_no_z_ack", {31'h0, mul_z_ack}, 32'h0);
        chk("split_no_result", {31'h0, result_stb_0}, 32'h0);
        mul_b_ack = 1'b1;
        tick();
        mul_b_ack = 1'b0;
        chk("split_b_drop", {31'h0, mul_b_stb}, 32'h0);
        chk("split_no_z_ack2", {31'h0, mul_z_ack}, 32'h0);
        tick();
        mul_z_stb = 1'b0;
        chk("split_cap", result_0, 32'h40200000);
        chk("split_z_ack", {31'h0, mul_z_ack}, 32'h1);
        tick();
        release_res(1'b0);

        // Backpressure, stray result_ack_1 and stray multiplier strobes
        do_reset();
        req_a_0 = 32'h40800000; req_b_0 = 32'h40800000; req_stb_0 = 1'b1;
        req_a_1 = 32'h3FC00000; req_b_1 = 32'h40000000;
        grant(1'b0, 32'h40800000, 32'h40800000);
        req_stb_1 = 1'b1;
        capture(1'b0, 32'h41800000);
        held = result_0;
        bad = 0;
        result_ack_1 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                mul_z = 32'hDEADBEEF; mul_z_stb = 1'b1;
                mul_a_ack = 1'b1; mul_b_ack = 1'b1;
            end
            if (i == 11) begin
                mul_z_stb = 1'b0; mul_a_ack = 1'b0; mul_b_ack = 1'b0;
            end
            if (i == 5) result_ack_1 = 1'b0;
            tick();
            if (result_0 !== held || result_stb_0 !== 1'b1 ||
                req_ack_1 !== 1'b0 || mul_z_ack !== 1'b0 ||
                result_stb_1 !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("bp_result_stable", held, 32'h41800000);
        chk("bp_hold_violations", bad, 0);
        release_res(1'b0);
        grant(1'b1, 32'h3FC00000, 32'h40000000);
        capture(1'b1, 32'h40400000);
        release_res(1'b1);

        // Asynchronous reset while waiting for the product
        req_a_0 = 32'h40000000; req_b_0 = 32'h40000000; req_stb_0 = 1'b1;
        grant(1'b0, 32'h40000000, 32'h40000000);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_mul", mul_a | mul_b, 32'h0);
        chk("arst_results", result_0 | result_1, 32'h0);
        chk("arst_flags", {27'h0, req_ack_0, mul_a_stb, mul_b_stb,
                           mul_z_ack, result_stb_0}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_no_req_ack", {30'h0, req_ack_1, req_ack_0}, 32'h0);
        chk("arst_idle", {31'h0, busy}, 32'h0);
        mul_z = 32'h40800000;
        mul_z_stb = 1'b1;
        tick();
        mul_z_stb = 1'b0;
        chk("arst_stray_z", {30'h0, result_stb_0, mul_z_ack}, 32'h0);
        req_a_0 = 32'hBF800000; req_b_0 = 32'h40E00000; req_stb_0 = 1'b1;
        grant(1'b0, 32'hBF800000, 32'h40E00000);
        capture(1'b0, 32'hC0E00000);
        release_res(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
